display_scan_mux: RTL
=====================

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

Interface
Parameters (name, default, meaning):
REQ-001 SHALL provide parameters:
- SCAN_DIV, 50000, clock cycles per digit slot; legal range 2..2^20.
- BLANK_CYC, 16, cycles at the start of each slot with all anodes off; legal range 1..SCAN_DIV-1.

Ports (name, direction, width, meaning):
REQ-002 SHALL provide these ports, clock and reset first:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; asynchronous assert, active-low.
- dig3  in  4  BCD tens-of-hours (leftmost digit).
- dig2  in  4  BCD hours.
- dig1  in  4  BCD tens-of-minutes.
- dig0  in  4  BCD minutes (rightmost digit).
- lz_blank  in  1  suppress dig3 when it is 0.
- blink_en  in  1  enable blinking of all digits (alarm ringing).
- blink_tick  in  1  one-cycle pulse that toggles the blink phase.
- bcd  out  4  digit code to the downstream BCD-to-7-segment decoder.
- an  out  4  anode enables, active-low; an[3] is dig3.
- colon  out  1  colon segment drive, active-high; follows the blink phase.
- frame_start  out  1  one-cycle pulse at the start of the dig3 slot.

Function
REQ-003 SHALL hold a slot counter (0..SCAN_DIV-1) and a digit index (3,2,1,0); the index decrements 3->2->1->0->3 when the counter wraps from SCAN_DIV-1 to 0.
REQ-004 SHALL behave as a two-state FSM per slot:
- BLANK while counter < BLANK_CYC, with an = 4'b1111.
- SHOW while counter >= BLANK_CYC, with exactly one an bit low, at the current index.
REQ-005 SHALL capture dig3..dig0 into a shadow register on the cycle the index moves to 3; bcd SHALL always come from the shadow register, so a frame never mixes two times.
REQ-006 SHALL register bcd and an; both change only on clk edges and are glitch-free.
REQ-007 SHALL drive bcd with the shadow digit for the current index during BLANK and SHOW. bcd is therefore stable before the anode turns on.
REQ-008 SHALL force an[3]=1 during SHOW when lz_blank=1 and shadow dig3==0; the bcd output is unaffected.
REQ-009 SHALL toggle the blink phase on each blink_tick while blink_en=1.
REQ-010 SHALL keep an = 4'b1111 for the whole frame while blink_en=1 and blink phase=1.
REQ-011 SHALL clear the blink phase to 0 in the cycle blink_en is low.
REQ-012 SHALL drive colon = ~blink phase when blink_en=1, and colon = 1 when blink_en=0.
REQ-013 SHALL pulse frame_start high for exactly one cycle, registered, coincident with counter=0 and index=3.
REQ-014 SHALL pass input codes 10..15 through to bcd unchanged; the downstream decoder handles them.
REQ-015 SHALL give blink_tick precedence over any other event in the same cycle; a tick at a slot wrap takes effect in the same cycle.
REQ-016 SHALL apply a blink phase change to an on the next clock edge, even mid-slot.

Reset
REQ-017 SHALL, while rst_n=0, asynchronously force all of the following:
- counter=0, index=3, shadow=0, blink phase=0.
- bcd=4'b0000, an=4'b1111, colon=1, frame_start=0.
REQ-018 SHALL, on the first rising clk edge after rst_n rises, start counting with index=3 and load the shadow from the inputs.
REQ-019 SHALL, when reset is asserted mid-slot, turn all anodes off immediately without waiting for a clock edge.

Verification
REQ-020 The bench SHALL cover these scenarios with SCAN_DIV=8, BLANK_CYC=2:
- Scan: digits 1,2,3,4 -> an sequence 0111,1011,1101,1110, each low for 6 cycles after 2 cycles of 1111, with bcd 1,2,3,4; frame_start every 32 cycles.
- Tearing: change dig0 from 4 to 9 mid-frame -> bcd shows 4 in the current frame and 9 only in the next frame.
- Leading zero: dig3=0, lz_blank=1 -> an[3] never low, bcd=0 in the dig3 slot; with lz_blank=0, an[3] is low for 6 cycles.
- Blink: blink_en=1, one blink_tick -> an=1111 and colon=0 until the next tick; drop blink_en -> the display resumes on the next edge.
- Async reset: assert rst_n=0 at counter=5 during SHOW -> an=1111 and bcd=0 with no clk edge.
- Async reset recovery: after release, frame_start appears 1 cycle after the first edge and then every 32 cycles.

Source files
------------

// File: rtl/display_scan_mux.sv
`default_nettype none
// ============================================================================
// Module   : display_scan_mux
// Brief    : Four-digit multiplexed display scanner with a blanking gap,
//            shadowed digits, leading-zero suppression and blinking.
// Revision : 1.0  initial release
// ============================================================================
module display_scan_mux #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dig3,
    input  logic [3:0] dig2,
    input  logic [3:0] dig1,
    input  logic [3:0] dig0,
    input  logic       lz_blank,
    input  logic       blink_en,
    input  logic       blink_tick,
    output logic [3:0] bcd,
    output logic [3:0] an,
    output logic       colon,
    output logic       frame_start
);

    localparam int c_CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } slot_state_t;

    logic            r_run;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_idx;
    logic [15:0]     r_shadow;
    logic            r_phase;
    logic [3:0]      r_bcd;
    logic [3:0]      r_an;
    logic            r_colon;
    logic            r_frame_start;

    logic [c_CW-1:0] w_cnt_nx;
    logic [1:0]      w_idx_nx;
    logic            w_load;
    logic            w_wrap;
    logic [15:0]     w_shadow_nx;
    logic            w_phase_nx;
    slot_state_t     w_state;
    logic [3:0]      w_an;
    logic [3:0]      w_bcd;
    logic            w_frame_start;

    // Outputs are registered from next-state values so they stay aligned
    // with the counter/index they describe.
    always_comb begin
        w_wrap   = (r_cnt == c_CW'(SCAN_DIV - 1));
        w_cnt_nx = r_cnt + c_CW'(1);
        w_idx_nx = r_idx;
        w_load   = 1'b0;
        if (!r_run) begin
            w_cnt_nx = '0;
            w_idx_nx = 2'd3;
            w_load   = 1'b1;
        end else if (w_wrap) begin
            w_cnt_nx = '0;
            w_idx_nx = r_idx - 2'd1;
            w_load   = (r_idx == 2'd0);
        end

        w_shadow_nx = w_load ? {dig3, dig2, dig1, dig0} : r_shadow;

        // A tick is honoured even on a slot wrap; dropping blink_en clears it.
        if (!blink_en)
            w_phase_nx = 1'b0;
        else if (blink_tick)
            w_phase_nx = ~r_phase;
        else
            w_phase_nx = r_phase;

        w_state = (w_cnt_nx < c_CW'(BLANK_CYC)) ? ST_BLANK : ST_SHOW;

        w_an = 4'b1111;
        if (w_state == ST_SHOW && !w_phase_nx) begin
            w_an[w_idx_nx] = 1'b0;
            if (w_idx_nx == 2'd3 && lz_blank && w_shadow_nx[15:12] == 4'd0)
                w_an[3] = 1'b1;
        end

        case (w_idx_nx)
            2'd3:    w_bcd = w_shadow_nx[15:12];
            2'd2:    w_bcd = w_shadow_nx[11:8];
            2'd1:    w_bcd = w_shadow_nx[7:4];
            default: w_bcd = w_shadow_nx[3:0];
        endcase

        w_frame_start = (w_cnt_nx == '0) && (w_idx_nx == 2'd3);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run         <= 1'b0;
            r_cnt         <= '0;
            r_idx         <= 2'd3;
            r_shadow      <= 16'h0000;
            r_phase       <= 1'b0;
            r_bcd         <= 4'b0000;
            r_an          <= 4'b1111;
            r_colon       <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_run         <= 1'b1;
            r_cnt         <= w_cnt_nx;
            r_idx         <= w_idx_nx;
            r_shadow      <= w_shadow_nx;
            r_phase       <= w_phase_nx;
            r_bcd         <= w_bcd;
            r_an          <= w_an;
            r_colon       <= ~w_phase_nx;
            r_frame_start <= w_frame_start;
        end
    end

    assign bcd         = r_bcd;
    assign an          = r_an;
    assign colon       = r_colon;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire
